// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared control types and default sizes for reset/control blocks
package reset_sequencer_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int POR_CYCLES_DEF = 16;
  typedef enum logic [2:0] {POR, IDLE, ASSERT, SETTLE, DONE} state_e;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: multi-flop synchroniser for an async level plus a rising-edge pulse
//   clock, reset_n : clock and async active-low reset
//   d_i            : asynchronous level input
//   sync_o         : synchronised level
//   rise_o         : one-cycle pulse on a synchronised 0->1 transition
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o
);
  logic [STAGES-1:0] sync_q;
  logic prev_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end
  assign sync_o = sync_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: turns a start request (and power-on) into a length-controlled reset pulse
//   clock, reset_n         : clock and async active-low reset
//   coe_start              : async request level; a synchronised rising edge triggers
//   assert_len, settle_len : pulse length and post-release settle length, sampled on trigger
//   coe_rst_out            : active-high reset conduit
//   busy, done             : sequence in progress / sequence complete
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int POR_CYCLES = POR_CYCLES_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             coe_start,
  input  logic [CNT_W-1:0] assert_len,
  input  logic [CNT_W-1:0] settle_len,
  output logic             coe_rst_out,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, settle_q, settle_d, settle_src;
  logic rst_q, busy_q, done_q, start_s, trig, last;
  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_sync (
    .clock  (clock),
    .reset_n(reset_n),
    .d_i    (coe_start),
    .sync_o (start_s),
    .rise_o (trig)
  );
  assign last = cnt_q == CNT_W'(1);
  // power-on has no trigger to sample at, so it uses the live settle length
  assign settle_src = state_q == POR ? settle_len : settle_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q - CNT_W'(1);
    settle_d = settle_q;
    case (state_q)
      POR, ASSERT: begin
        // counter is still zero only on the first clock after reset release
        if (state_q == POR && cnt_q == '0) cnt_d = CNT_W'(POR_CYCLES);
        else if (last) begin
          state_d = settle_src == '0 ? DONE : SETTLE;
          cnt_d = settle_src;
        end
      end
      IDLE: begin
        cnt_d = cnt_q;
        if (trig) begin
          state_d = ASSERT;
          cnt_d = assert_len == '0 ? CNT_W'(1) : assert_len;
          settle_d = settle_len;
        end
      end
      SETTLE: if (last) state_d = DONE;
      DONE: begin
        cnt_d = cnt_q;
        if (!start_s) state_d = IDLE;
      end
      default: begin
        state_d = POR;
        cnt_d = '0;
      end
    endcase
  end
  // outputs are registered from the next state so they change with the state itself
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= POR;
      cnt_q <= '0;
      settle_q <= '0;
      rst_q <= 1'b1;
      busy_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      settle_q <= settle_d;
      rst_q <= state_d inside {POR, ASSERT};
      busy_q <= state_d inside {POR, ASSERT, SETTLE};
      done_q <= state_d == DONE;
    end
  end
  assign coe_rst_out = rst_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed self-checking bench for reset_sequencer
module tb_reset_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic coe_start = 1'b0;
  logic [15:0] assert_len = '0;
  logic [15:0] settle_len = 16'd4;
  logic coe_rst_out, busy, done;
  int n_chk = 0;
  int n_pass = 0;
  reset_sequencer dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .coe_start  (coe_start),
    .assert_len (assert_len),
    .settle_len (settle_len),
    .coe_rst_out(coe_rst_out),
    .busy       (busy),
    .done       (done)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  function automatic logic pick(input int s);
    return s == 0 ? coe_rst_out : s == 1 ? busy : done;
  endfunction
  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask
  task automatic run_len(input int s, input int lim, output int n);
    n = 0;
    while (pick(s) === 1'b1 && n < lim) begin
      n++;
      step(1);
    end
  endtask
  initial begin
    int n, hi, rises;
    logic prev;
    step(4);
    chk("reset_rst", coe_rst_out, 1);
    chk("reset_busy", busy, 1);
    chk("reset_done", done, 0);
    step(1);
    reset_n = 1'b1;
    step(1);
    run_len(0, 100, n);
    chk("por_len", n, 16);
    run_len(1, 100, n);
    chk("por_settle_len", n, 4);
    chk("por_done", done, 1);
    chk("por_done_busy", busy, 0);
    step(1);
    chk("por_done_clear", done, 0);
    assert_len = 16'd10;
    settle_len = 16'd3;
    coe_start = 1'b1;
    step(1);
    chk("lat_edge1", coe_rst_out, 0);
    step(1);
    chk("lat_edge2", coe_rst_out, 0);
    step(1);
    chk("lat_edge3", coe_rst_out, 1);
    chk("assert_busy", busy, 1);
    assert_len = 16'd2;
    settle_len = 16'd7;
    run_len(0, 100, n);
    chk("assert_len10", n, 10);
    run_len(1, 100, n);
    chk("settle_len3", n, 3);
    chk("normal_done", done, 1);
    step(5);
    chk("done_hold", done, 1);
    coe_start = 1'b0;
    step(2);
    chk("done_before_drop", done, 1);
    step(1);
    chk("done_drop", done, 0);
    assert_len = '0;
    settle_len = '0;
    coe_start = 1'b1;
    step(3);
    chk("zero_rise", coe_rst_out, 1);
    run_len(0, 100, n);
    chk("zero_assert_len", n, 1);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    coe_start = 1'b0;
    step(3);
    chk("zero_done_clear", done, 0);
    assert_len = 16'd20;
    settle_len = 16'd2;
    coe_start = 1'b1;
    step(3);
    hi = 0;
    rises = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (coe_rst_out) hi++;
      if (coe_rst_out && !prev) rises++;
      prev = coe_rst_out;
      if (i == 2) coe_start = 1'b0;
      if (i == 6) coe_start = 1'b1;
      step(1);
    end
    chk("retrig_len", hi, 20);
    chk("retrig_pulses", rises, 1);
    chk("retrig_done", done, 1);
    hi = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (coe_rst_out) hi++;
    end
    chk("held_no_pulse", hi, 0);
    chk("held_done", done, 1);
    coe_start = 1'b0;
    step(3);
    chk("held_release", done, 0);
    assert_len = 16'd5;
    settle_len = 16'd1;
    coe_start = 1'b1;
    step(3);
    chk("reraise_rise", coe_rst_out, 1);
    run_len(0, 100, n);
    chk("reraise_len", n, 5);
    coe_start = 1'b0;
    step(4);
    assert_len = 16'hFFFF;
    settle_len = '0;
    coe_start = 1'b1;
    step(3);
    run_len(0, 70000, n);
    chk("ones_len", n, 65535);
    chk("ones_done", done, 1);
    coe_start = 1'b0;
    step(4);
    assert_len = 16'd20;
    settle_len = 16'd2;
    coe_start = 1'b1;
    step(3);
    chk("ar_rise", coe_rst_out, 1);
    step(4);
    #2 reset_n = 1'b0;
    coe_start = 1'b0;
    #1;
    chk("ar_rst", coe_rst_out, 1);
    chk("ar_busy", busy, 1);
    chk("ar_done", done, 0);
    step(2);
    chk("ar_hold", coe_rst_out, 1);
    reset_n = 1'b1;
    step(1);
    run_len(0, 100, n);
    chk("ar_por_len", n, 16);
    run_len(1, 100, n);
    chk("ar_settle_len", n, 2);
    chk("ar_final_done", done, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
